// File: rtl/fn4_bist_checker.sv
// -----------------------------------------------------------------------------
// fn4_bist_checker
//   Self-test engine for the 4-input function block
//   F(A,B,C,D) = PI M(0,1,2,8,10,12,14).
//
//   The engine walks the patterns 0000..1111 (A = MSB) onto the block inputs.
//   Each pattern is held SETTLE+1 cycles, and F is sampled on the last of
//   those cycles. Every sample is compared against the golden truth table.
//
//   State table:
//     state | meaning
//     IDLE  | waiting for start; no results latched, or a run was aborted
//     RUN   | applying patterns and sampling F_in
//     DONE  | run complete; results held until the next start
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   begin a run (honoured in IDLE/DONE only)
//   abort      in   cancel a run (honoured in RUN only)
//   F_in       in   output of the function block under test
//   A,B,C,D    out  registered pattern bits 3..0
//   busy       out  high while in RUN
//   done       out  high in DONE after a completed run
//   pass       out  valid with done; 1 when no mismatches were seen
//   err_count  out  mismatch count, 0..16
//   fail_seen  out  at least one mismatch this run
//   first_fail out  index of the first mismatching pattern
//   resp_vec   out  captured F; bit i is the sample for pattern i
// -----------------------------------------------------------------------------
module fn4_bist_checker #(
  parameter logic [15:0] GOLDEN = 16'hAAF8,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        F_in,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic        fail_seen,
  output logic [3:0]  first_fail,
  output logic [15:0] resp_vec
);

  localparam logic [3:0] SETTLE_L = SETTLE[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [3:0]  idx, idx_n;
  logic [3:0]  wait_cnt, wait_cnt_n;
  logic        busy_n, done_n, pass_n, fail_seen_n;
  logic [4:0]  err_count_n;
  logic [3:0]  first_fail_n;
  logic [15:0] resp_vec_n;
  logic        mismatch;

  // The pattern register drives the block directly.
  assign {A, B, C, D} = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      wait_cnt   <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      fail_seen  <= 1'b0;
      first_fail <= 4'd0;
      resp_vec   <= 16'd0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      wait_cnt   <= wait_cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_count  <= err_count_n;
      fail_seen  <= fail_seen_n;
      first_fail <= first_fail_n;
      resp_vec   <= resp_vec_n;
    end
  end

  always_comb begin
    state_n      = state;
    idx_n        = idx;
    wait_cnt_n   = wait_cnt;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    err_count_n  = err_count;
    fail_seen_n  = fail_seen;
    first_fail_n = first_fail;
    resp_vec_n   = resp_vec;
    mismatch     = (F_in != GOLDEN[idx]);

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = RUN;
          idx_n        = 4'd0;
          wait_cnt_n   = 4'd0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          err_count_n  = 5'd0;
          fail_seen_n  = 1'b0;
          first_fail_n = 4'd0;
          resp_vec_n   = 16'd0;
        end
      end

      RUN: begin
        if (abort) begin
          // Partial results stay visible for diagnosis after an abort.
          state_n    = IDLE;
          idx_n      = 4'd0;
          wait_cnt_n = 4'd0;
          busy_n     = 1'b0;
          done_n     = 1'b0;
          pass_n     = 1'b0;
        end else if (wait_cnt < SETTLE_L) begin
          wait_cnt_n = wait_cnt + 4'd1;
        end else begin
          wait_cnt_n      = 4'd0;
          resp_vec_n[idx] = F_in;
          if (mismatch) begin
            err_count_n = err_count + 5'd1;
            if (!fail_seen) begin
              fail_seen_n  = 1'b1;
              first_fail_n = idx;
            end
          end
          if (idx == 4'd15) begin
            state_n = DONE;
            idx_n   = 4'd0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            // The final sample is included in the pass decision.
            pass_n  = (err_count_n == 5'd0);
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fn4_bist_checker.sv
// -----------------------------------------------------------------------------
// tb_fn4_bist_checker
//   Directed bench for fn4_bist_checker with SETTLE=2. A behavioural function
//   block model feeds F_in and can inject stuck-at and single-pattern faults.
// -----------------------------------------------------------------------------
module tb_fn4_bist_checker;

  localparam logic [15:0] GOLD = 16'hAAF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        F_in;
  logic        A, B, C, D;
  logic        busy, done, pass, fail_seen;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;
  logic [15:0] resp_vec;
  logic [3:0]  pat;

  // Fault model: 0 fault-free, 1 stuck-at-1, 2 stuck-at-0, 3 forced 1 at pattern 10.
  int fault_mode = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign pat = {A, B, C, D};

  always_comb begin
    case (fault_mode)
      1:       F_in = 1'b1;
      2:       F_in = 1'b0;
      3:       F_in = (pat == 4'd10) ? 1'b1 : GOLD[pat];
      default: F_in = GOLD[pat];
    endcase
  end

  fn4_bist_checker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .F_in       (F_in),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_seen  (fail_seen),
    .first_fail (first_fail),
    .resp_vec   (resp_vec)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pulse start for one edge; returns at the falling edge after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Follows a whole run from the start edge, checking busy and the pattern
  // sequence. Optionally injects a start pulse while idx=4 (must be ignored).
  task automatic follow_run(input bit restart_pulse);
    for (int n = 0; n < 48; n++) begin
      check_val("run_busy", {31'd0, busy}, 32'd1);
      check_val("run_pat", {28'd0, pat}, n / 3);
      start = (restart_pulse && n == 12);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic pass_e, input logic [4:0] err_e,
                               input logic fail_e, input logic [3:0] first_e,
                               input logic [15:0] resp_e);
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_pass"}, {31'd0, pass}, {31'd0, pass_e});
    check_val({tag, "_err"}, {27'd0, err_count}, {27'd0, err_e});
    check_val({tag, "_fseen"}, {31'd0, fail_seen}, {31'd0, fail_e});
    check_val({tag, "_first"}, {28'd0, first_fail}, {28'd0, first_e});
    check_val({tag, "_resp"}, {16'd0, resp_vec}, {16'd0, resp_e});
    check_val({tag, "_pat"}, {28'd0, pat}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_pat"}, {28'd0, pat}, 32'd0);
    check_val({tag, "_flags"}, {28'd0, busy, done, pass, fail_seen}, 32'd0);
    check_val({tag, "_err"}, {27'd0, err_count}, 32'd0);
    check_val({tag, "_first"}, {28'd0, first_fail}, 32'd0);
    check_val({tag, "_resp"}, {16'd0, resp_vec}, 32'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Fault-free run
    fault_mode = 0;
    pulse_start();
    follow_run(1'b0);
    check_results("clean", 1'b1, 5'd0, 1'b0, 4'd0, 16'hAAF8);

    // abort is ignored in DONE
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("done_abort_ign", {31'd0, done}, 32'd1);

    // Stuck-at-1
    fault_mode = 1;
    pulse_start();
    follow_run(1'b0);
    check_results("sa1", 1'b0, 5'd7, 1'b1, 4'd0, 16'hFFFF);

    // Stuck-at-0
    fault_mode = 2;
    pulse_start();
    follow_run(1'b0);
    check_results("sa0", 1'b0, 5'd9, 1'b1, 4'd3, 16'h0000);

    // Single fault at pattern 10
    fault_mode = 3;
    pulse_start();
    follow_run(1'b0);
    check_results("p10", 1'b0, 5'd1, 1'b1, 4'd10, 16'hAEF8);

    // Abort while idx=5 (stuck-at-1 so partial results are non-zero)
    fault_mode = 1;
    pulse_start();
    check_val("ab_start_clr", {16'd0, resp_vec}, 32'd0);
    repeat (15) @(negedge clk);
    check_val("ab_at5", {28'd0, pat}, 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("ab_busy", {31'd0, busy}, 32'd0);
    check_val("ab_done", {31'd0, done}, 32'd0);
    check_val("ab_pat", {28'd0, pat}, 32'd0);
    check_val("ab_resp", {16'd0, resp_vec}, 32'h001F);
    check_val("ab_err", {27'd0, err_count}, 32'd3);
    check_val("ab_first", {27'd0, fail_seen, first_fail}, 32'h10);
    @(negedge clk);
    check_val("ab_stay_idle", {31'd0, busy}, 32'd0);

    // Restart after abort clears results and completes cleanly
    fault_mode = 0;
    pulse_start();
    check_val("rs_clr_err", {27'd0, err_count}, 32'd0);
    check_val("rs_clr_resp", {16'd0, resp_vec}, 32'd0);
    follow_run(1'b0);
    check_results("rs", 1'b1, 5'd0, 1'b0, 4'd0, 16'hAAF8);

    // Async reset mid-run at idx=9
    pulse_start();
    repeat (27) @(negedge clk);
    check_val("rst_at9", {28'd0, pat}, 32'd9);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst_idle");

    // start pulse during RUN must not restart the sequence
    pulse_start();
    follow_run(1'b1);
    check_results("norestart", 1'b1, 5'd0, 1'b0, 4'd0, 16'hAAF8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
